// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI register bridge.
// Used by both builds of the bridge (SPI_REG_BRIDGE_AUTOINC_EN defined or undefined).
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_RD     = 3'd4
    } state_t;

    localparam int         CMD_RD_BIT    = 7;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hA5;
    localparam logic       CS_DEASSERTED = 1'b1;

endpackage

// File: rtl/spi_reg_bridge_cs_sync.sv
// Two-flop synchroniser for the raw chip-select pin with rising-edge (frame end) detect.
// The flops reset to the deasserted level, so a reset never looks like a frame end.
module cs_sync
    import spi_reg_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic cs_rise
);

    logic cs_meta;
    logic cs_level;
    logic cs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta  <= CS_DEASSERTED;
            cs_level <= CS_DEASSERTED;
            cs_prev  <= CS_DEASSERTED;
        end else begin
            cs_meta  <= cs;
            cs_level <= cs_meta;
            cs_prev  <= cs_level;
        end
    end

    assign cs_rise = cs_level & ~cs_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder turning SPI frames into register-port reads and writes.
// SPI_REG_BRIDGE_AUTOINC_EN: when defined the address advances after each data byte.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [7:0]        rxd_out,
    input  logic              rxd_flag,
    output logic [7:0]        txd_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err
);

    state_t            state;
    state_t            state_next;
    logic [7:0]        txd_next;
    logic [ADDR_W-1:0] addr_next;
    logic              wr_next;
    logic [7:0]        wdata_next;
    logic              rd_next;
    logic              err_next;
    logic              data_seen;
    logic              seen_next;
    logic              cs_rise;

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
        return a;
`endif
    endfunction

    cs_sync u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .cs_rise (cs_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            txd_data  <= IDLE_BYTE;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= 8'h00;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
            data_seen <= 1'b0;
        end else begin
            state     <= state_next;
            txd_data  <= txd_next;
            reg_addr  <= addr_next;
            reg_wr    <= wr_next;
            reg_wdata <= wdata_next;
            reg_rd    <= rd_next;
            frame_err <= err_next;
            data_seen <= seen_next;
        end
    end

    always_comb begin
        state_next = state;
        txd_next   = txd_data;
        addr_next  = reg_addr;
        wr_next    = 1'b0;
        wdata_next = reg_wdata;
        rd_next    = 1'b0;
        err_next   = frame_err;
        seen_next  = data_seen;

        // The write address must stay put while reg_wr is high, so it advances one cycle later.
        if (reg_wr) begin
            addr_next = step_addr(reg_addr);
        end

        if (cs_rise) begin
            // Frame end outranks any byte arriving in the same cycle.
            state_next = ST_IDLE;
            txd_next   = IDLE_BYTE;
            seen_next  = 1'b0;
            if ((state == ST_WR || state == ST_RD) && !data_seen) begin
                err_next = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rxd_flag) begin
                        addr_next = rxd_out[ADDR_W-1:0];
                        seen_next = 1'b0;
                        if (rxd_out[CMD_RD_BIT]) begin
                            state_next = ST_RD_REQ;
                            rd_next    = 1'b1;
                        end else begin
                            state_next = ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (rxd_flag) begin
                        wr_next    = 1'b1;
                        wdata_next = rxd_out;
                        seen_next  = 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    state_next = ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    txd_next   = reg_rdata;
                    addr_next  = step_addr(reg_addr);
                    state_next = ST_RD;
                end
                ST_RD: begin
                    // The byte just shifted out is consumed; prefetch the next one.
                    if (rxd_flag) begin
                        seen_next  = 1'b1;
                        state_next = ST_RD_REQ;
                        rd_next    = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge with a behavioural register port.
// Expected addresses follow SPI_REG_BRIDGE_AUTOINC_EN when it is defined.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic [7:0] rxd_out = 8'h00;
    logic       rxd_flag = 1'b0;
    logic [7:0] txd_data;
    logic [6:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    int vectors = 0;
    int errors = 0;

    int         wr_n = 0;
    int         rd_n = 0;
    logic [6:0] wr_a [0:63];
    logic [7:0] wr_d [0:63];

    spi_reg_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rxd_out   (rxd_out),
        .rxd_flag  (rxd_flag),
        .txd_data  (txd_data),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_reg(input logic [6:0] a);
        case (a)
            7'd3:    return 8'h3C;
            7'd4:    return 8'h4D;
            default: return {1'b0, a} ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [6:0] nxt(input logic [6:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
        return a + 7'd1;
`else
        return a;
`endif
    endfunction

    // Register port model: read data one cycle after reg_rd, log every write.
    always @(posedge clk) begin
        if (reg_rd) begin
            reg_rdata <= model_reg(reg_addr);
            rd_n      <= rd_n + 1;
        end
        if (reg_wr && wr_n < 64) begin
            wr_a[wr_n] <= reg_addr;
            wr_d[wr_n] <= reg_wdata;
            wr_n       <= wr_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxd_out  = b;
        rxd_flag = 1'b1;
        @(negedge clk);
        rxd_flag = 1'b0;
        repeat (64) @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // One read byte slot with cycle-accurate checks of reg_rd, reg_addr and txd_data.
    task automatic read_slot(input logic [7:0] b, input logic [6:0] exp_addr,
                             input logic [7:0] old_txd, input logic [7:0] new_txd);
        @(negedge clk);
        rxd_out  = b;
        rxd_flag = 1'b1;
        @(negedge clk);
        rxd_flag = 1'b0;
        vectors++;
        if ({reg_rd, reg_addr, txd_data} !== {1'b1, exp_addr, old_txd}) begin
            errors++;
            $display("FAIL read_t1 rd/addr/txd got %b/%0d/%h exp 1/%0d/%h",
                     reg_rd, reg_addr, txd_data, exp_addr, old_txd);
        end
        @(negedge clk);
        vectors++;
        if ({reg_rd, txd_data} !== {1'b0, old_txd}) begin
            errors++;
            $display("FAIL read_t2 rd/txd got %b/%h exp 0/%h", reg_rd, txd_data, old_txd);
        end
        @(negedge clk);
        vectors++;
        if (txd_data !== new_txd) begin
            errors++;
            $display("FAIL read_t3 txd got %h exp %h", txd_data, new_txd);
        end
        repeat (61) @(negedge clk);
        vectors++;
        if (txd_data !== new_txd) begin
            errors++;
            $display("FAIL read_hold txd got %h exp %h", txd_data, new_txd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({txd_data, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !==
            {8'hA5, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs txd=%h addr=%0d wr=%b wdata=%h rd=%b err=%b exp a5/0/0/00/0/0",
                     txd_data, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_burst();
        int wb = wr_n;
        int rb = rd_n;
        cs_begin();
        send_byte(8'h05);
        @(negedge clk);
        rxd_out  = 8'h11;
        rxd_flag = 1'b1;
        @(negedge clk);
        rxd_flag = 1'b0;
        vectors++;
        if ({reg_wr, reg_addr, reg_wdata} !== {1'b1, 7'd5, 8'h11}) begin
            errors++;
            $display("FAIL write_timing wr/addr/wdata got %b/%0d/%h exp 1/5/11",
                     reg_wr, reg_addr, reg_wdata);
        end
        repeat (64) @(negedge clk);
        send_byte(8'h22);
        cs_end();
        vectors++;
        if (wr_n - wb !== 2) begin
            errors++;
            $display("FAIL write_count got %0d exp 2", wr_n - wb);
        end
        vectors++;
        if ({wr_a[wb], wr_d[wb]} !== {7'd5, 8'h11}) begin
            errors++;
            $display("FAIL write0 got addr %0d data %h exp 5 11", wr_a[wb], wr_d[wb]);
        end
        vectors++;
        if ({wr_a[wb+1], wr_d[wb+1]} !== {nxt(7'd5), 8'h22}) begin
            errors++;
            $display("FAIL write1 got addr %0d data %h exp %0d 22", wr_a[wb+1], wr_d[wb+1], nxt(7'd5));
        end
        vectors++;
        if (rd_n - rb !== 0) begin
            errors++;
            $display("FAIL write_no_rd got %0d reads exp 0", rd_n - rb);
        end
    endtask

    task automatic test_read_burst();
        int rb = rd_n;
        int wb = wr_n;
        logic [6:0] a1;
        logic [6:0] a2;
        a1 = nxt(7'd3);
        a2 = nxt(a1);
        cs_begin();
        vectors++;
        if (txd_data !== 8'hA5) begin
            errors++;
            $display("FAIL read_miso0 got %h exp a5", txd_data);
        end
        read_slot(8'h83, 7'd3, 8'hA5, 8'h3C);
        read_slot(8'h00, a1, 8'h3C, model_reg(a1));
        read_slot(8'hFF, a2, model_reg(a1), model_reg(a2));
        cs_end();
        vectors++;
        if ({txd_data, frame_err} !== {8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL read_end txd/err got %h/%b exp a5/0", txd_data, frame_err);
        end
        vectors++;
        if ({rd_n - rb, wr_n - wb} !== {32'd3, 32'd0}) begin
            errors++;
            $display("FAIL read_counts got rd %0d wr %0d exp 3 0", rd_n - rb, wr_n - wb);
        end
    endtask

    task automatic test_wrap();
        int wb = wr_n;
        cs_begin();
        send_byte(8'h7F);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cs_end();
        vectors++;
        if (wr_n - wb !== 2) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 2", wr_n - wb);
        end
        vectors++;
        if ({wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {7'd127, 8'hAA, nxt(7'd127), 8'hBB}) begin
            errors++;
            $display("FAIL wrap_writes got %0d:%h %0d:%h exp 127:aa %0d:bb",
                     wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1], nxt(7'd127));
        end
    endtask

    task automatic test_empty_frame();
        int wb = wr_n;
        int rb = rd_n;
        vectors++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_pre_err got %b exp 0", frame_err);
        end
        cs_begin();
        send_byte(8'h10);
        cs_end();
        vectors++;
        if ({frame_err, txd_data} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL empty_err_txd got %b/%h exp 1/a5", frame_err, txd_data);
        end
        vectors++;
        if ({wr_n - wb, rd_n - rb} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL empty_strobes got wr %0d rd %0d exp 0 0", wr_n - wb, rd_n - rb);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL empty_sticky got %b exp 1", frame_err);
        end
    endtask

    task automatic test_abort();
        int wb;
        cs_begin();
        send_byte(8'h83);
        vectors++;
        if (txd_data !== 8'h3C) begin
            errors++;
            $display("FAIL abort_pre_txd got %h exp 3c", txd_data);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({txd_data, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !==
            {8'hA5, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset txd=%h addr=%0d wr=%b wdata=%h rd=%b err=%b exp a5/0/0/00/0/0",
                     txd_data, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wb = wr_n;
        send_byte(8'h02);
        send_byte(8'h55);
        cs_end();
        vectors++;
        if ({wr_n - wb} !== 32'd1 || {wr_a[wb], wr_d[wb]} !== {7'd2, 8'h55}) begin
            errors++;
            $display("FAIL abort_new_cmd got %0d writes first %0d:%h exp 1 write 2:55",
                     wr_n - wb, wr_a[wb], wr_d[wb]);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err got %b exp 0", frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_empty_frame();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
